// File: rtl/macc_seq.sv
// macc_seq - operand/result sequencer for the matrix multiply-accumulate datapath.
//
// Computes the control stream for C = A x B, with B held transposed so that
// row j of the B store is column j of B. The (i, j, k) loops are walked in
// that nesting order (k innermost). Every issued term reads one A and one B
// operand, then travels down a shift pipe that lines up the MAC controls and
// the C write with the RAM and MAC latencies.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   start                    begin an operation (accepted only when idle)
//   hold                     suspend operand issue; in-flight terms still drain
//   m_idx_size/k_idx_size/n_idx_size
//                            dimensions minus one (M rows, K inner, N columns)
//   busy, done               operation in progress / one-cycle completion pulse
//   rd_en, a_addr, b_addr    operand read strobe and addresses for A and B stores
//   mac_en, acc_clr          multiply-accumulate enable / load product instead
//   c_we, c_addr             result write strobe and address for the C store
module macc_seq #(
    parameter int ADDR_MSB         = 11,
    parameter int MAT_IDX_SIZE_MSB = 3,
    parameter int RD_LAT           = 1,
    parameter int MAC_LAT          = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      hold,
    input  logic [MAT_IDX_SIZE_MSB:0] m_idx_size,
    input  logic [MAT_IDX_SIZE_MSB:0] k_idx_size,
    input  logic [MAT_IDX_SIZE_MSB:0] n_idx_size,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_MSB:0]         a_addr,
    output logic [ADDR_MSB:0]         b_addr,
    output logic                      mac_en,
    output logic                      acc_clr,
    output logic                      c_we,
    output logic [ADDR_MSB:0]         c_addr
);

    localparam int AW = ADDR_MSB + 1;
    localparam int IW = MAT_IDX_SIZE_MSB + 1;
    localparam int PL = RD_LAT + MAC_LAT;   // pipe depth from issue to C write

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;

    logic [IW-1:0] m_sz, k_sz, n_sz;
    logic [IW-1:0] i_cnt, j_cnt, k_cnt;
    logic [AW-1:0] a_base, b_base, c_cnt;
    logic [AW-1:0] k_len;

    logic          issue, k_last, j_last, i_last, term_last, pipe_busy;

    logic [PL-1:0] vld_p, first_p, last_p;
    logic [AW-1:0] caddr_p [PL];

    assign k_len     = AW'(k_sz) + AW'(1);
    assign issue     = (state == S_RUN) && !hold;
    assign k_last    = (k_cnt == k_sz);
    assign j_last    = (j_cnt == n_sz);
    assign i_last    = (i_cnt == m_sz);
    assign term_last = issue && k_last && j_last && i_last;
    // The final stage only carries the C write; once everything ahead of it is
    // empty, the write lands this cycle and done can follow in the next one.
    assign pipe_busy = |vld_p[PL-2:0];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_RUN;
            S_RUN:   if (term_last)  state_nxt = S_DRAIN;
            S_DRAIN: if (!pipe_busy) state_nxt = S_DONE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        rd_en   = issue;
        a_addr  = a_base + AW'(k_cnt);
        b_addr  = b_base + AW'(k_cnt);
        mac_en  = vld_p[RD_LAT-1];
        acc_clr = vld_p[RD_LAT-1] && first_p[RD_LAT-1];
        c_we    = vld_p[PL-1] && last_p[PL-1];
        c_addr  = caddr_p[PL-1];
    end

    // Loop counters and running address bases (no multipliers)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_sz   <= '0;
            k_sz   <= '0;
            n_sz   <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            a_base <= '0;
            b_base <= '0;
            c_cnt  <= '0;
        end else if (state == S_IDLE && start) begin
            m_sz   <= m_idx_size;
            k_sz   <= k_idx_size;
            n_sz   <= n_idx_size;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            a_base <= '0;
            b_base <= '0;
            c_cnt  <= '0;
        end else if (issue) begin
            if (!k_last) begin
                k_cnt <= k_cnt + IW'(1);
            end else begin
                k_cnt <= '0;
                c_cnt <= c_cnt + AW'(1);
                if (!j_last) begin
                    j_cnt  <= j_cnt + IW'(1);
                    b_base <= b_base + k_len;
                end else begin
                    j_cnt  <= '0;
                    b_base <= '0;
                    i_cnt  <= i_cnt + IW'(1);
                    a_base <= a_base + k_len;
                end
            end
        end
    end

    // Issue -> stage 0 ... stage PL-1 (C write); hold never stalls this pipe
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
            for (int n = 0; n < PL; n++) caddr_p[n] <= '0;
        end else begin
            vld_p   <= {vld_p[PL-2:0], issue};
            first_p <= {first_p[PL-2:0], issue && (k_cnt == '0)};
            last_p  <= {last_p[PL-2:0], issue && k_last};
            caddr_p[0] <= c_cnt;
            for (int n = 1; n < PL; n++) caddr_p[n] <= caddr_p[n-1];
        end
    end

endmodule

// File: tb/tb_macc_seq.sv
module tb_macc_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  m_idx_size = '0;
    logic [3:0]  k_idx_size = '0;
    logic [3:0]  n_idx_size = '0;
    logic        busy, done, rd_en, mac_en, acc_clr, c_we;
    logic [11:0] a_addr, b_addr, c_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle trace of the last captured run (bit c = cycle c)
    logic [31:0] rd_m, mac_m, clr_m, we_m, done_m, busy_m;
    logic [11:0] a_t [32];
    logic [11:0] b_t [32];
    logic [11:0] ca_t [32];

    macc_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .hold(hold),
        .m_idx_size(m_idx_size), .k_idx_size(k_idx_size), .n_idx_size(n_idx_size),
        .busy(busy), .done(done), .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .mac_en(mac_en), .acc_clr(acc_clr), .c_we(c_we), .c_addr(c_addr)
    );

    always #5 CLK = ~CLK;

    // Cycle 0 begins at the next rising edge; start is asserted during cycle 0.
    task automatic capture(input int ncyc, input logic [3:0] m, input logic [3:0] k,
                           input logic [3:0] n, input logic [31:0] hold_m,
                           input int start2, input int rst_c, input bit scramble);
        rd_m = '0; mac_m = '0; clr_m = '0; we_m = '0; done_m = '0; busy_m = '0;
        @(posedge CLK);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(posedge CLK);
            #1;
            start = (c == 0) || (c == start2);
            hold  = hold_m[c];
            RST   = (c == rst_c);
            if (scramble && c > 0) begin
                m_idx_size = 4'd3; k_idx_size = 4'd3; n_idx_size = 4'd3;
            end else begin
                m_idx_size = m; k_idx_size = k; n_idx_size = n;
            end
            @(negedge CLK);
            rd_m[c] = rd_en; mac_m[c] = mac_en; clr_m[c] = acc_clr;
            we_m[c] = c_we; done_m[c] = done; busy_m[c] = busy;
            a_t[c] = a_addr; b_t[c] = b_addr; ca_t[c] = c_addr;
        end
        #1;
        start = 1'b0; hold = 1'b0; RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({busy, done, rd_en, mac_en, acc_clr, c_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, done, rd_en, mac_en, acc_clr, c_we});
        end
        n_cmp++;
        if ({a_addr, b_addr, c_addr} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_addr: got a=%0d b=%0d c=%0d want 0", a_addr, b_addr, c_addr);
        end
        #1 RST = 1'b0;
    endtask

    task automatic test_1x1x1();
        capture(10, 4'd0, 4'd0, 4'd0, 32'h0, -1, -1, 1'b0);
        n_cmp++;
        if (rd_m !== 32'h2) begin n_err++; $display("FAIL 111_rd: got %h want %h", rd_m, 32'h2); end
        n_cmp++;
        if (a_t[1] !== 12'd0 || b_t[1] !== 12'd0) begin
            n_err++; $display("FAIL 111_addr: got a=%0d b=%0d want 0 0", a_t[1], b_t[1]);
        end
        n_cmp++;
        if (mac_m !== 32'h4) begin n_err++; $display("FAIL 111_mac: got %h want %h", mac_m, 32'h4); end
        n_cmp++;
        if (clr_m !== 32'h4) begin n_err++; $display("FAIL 111_clr: got %h want %h", clr_m, 32'h4); end
        n_cmp++;
        if (we_m !== 32'h10 || ca_t[4] !== 12'd0) begin
            n_err++; $display("FAIL 111_cwe: got %h c_addr=%0d want %h 0", we_m, ca_t[4], 32'h10);
        end
        n_cmp++;
        if (done_m !== 32'h20) begin n_err++; $display("FAIL 111_done: got %h want %h", done_m, 32'h20); end
        n_cmp++;
        if (busy_m !== 32'h3E) begin n_err++; $display("FAIL 111_busy: got %h want %h", busy_m, 32'h3E); end
    endtask

    task automatic test_2x2x2();
        int exp_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int exp_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int we_c  [4] = '{5, 7, 9, 11};
        capture(16, 4'd1, 4'd1, 4'd1, 32'h0, -1, -1, 1'b0);
        n_cmp++;
        if (rd_m !== 32'h1FE) begin n_err++; $display("FAIL 222_rd: got %h want %h", rd_m, 32'h1FE); end
        for (int t = 0; t < 8; t++) begin
            n_cmp++;
            if (a_t[t+1] !== 12'(exp_a[t]) || b_t[t+1] !== 12'(exp_b[t])) begin
                n_err++;
                $display("FAIL 222_addr[%0d]: got a=%0d b=%0d want a=%0d b=%0d", t, a_t[t+1], b_t[t+1], exp_a[t], exp_b[t]);
            end
        end
        n_cmp++;
        if (mac_m !== 32'h3FC) begin n_err++; $display("FAIL 222_mac: got %h want %h", mac_m, 32'h3FC); end
        n_cmp++;
        if (clr_m !== 32'h154) begin n_err++; $display("FAIL 222_clr: got %h want %h", clr_m, 32'h154); end
        n_cmp++;
        if (we_m !== 32'hAA0) begin n_err++; $display("FAIL 222_cwe: got %h want %h", we_m, 32'hAA0); end
        for (int t = 0; t < 4; t++) begin
            n_cmp++;
            if (ca_t[we_c[t]] !== 12'(t)) begin
                n_err++; $display("FAIL 222_caddr[%0d]: got %0d want %0d", t, ca_t[we_c[t]], t);
            end
        end
        n_cmp++;
        if (done_m !== 32'h1000) begin n_err++; $display("FAIL 222_done: got %h want %h", done_m, 32'h1000); end
    endtask

    task automatic test_hold();
        int rd_c  [8] = '{1, 2, 5, 6, 7, 8, 9, 10};
        int exp_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
        int exp_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int we_c  [4] = '{5, 9, 11, 13};
        capture(18, 4'd1, 4'd1, 4'd1, 32'h18, -1, -1, 1'b0);
        n_cmp++;
        if (rd_m !== 32'h7E6) begin n_err++; $display("FAIL hold_rd: got %h want %h", rd_m, 32'h7E6); end
        n_cmp++;
        if (a_t[3] !== 12'd0 || a_t[4] !== 12'd0) begin
            n_err++; $display("FAIL hold_a_frozen: got %0d %0d want 0 0", a_t[3], a_t[4]);
        end
        for (int t = 0; t < 8; t++) begin
            n_cmp++;
            if (a_t[rd_c[t]] !== 12'(exp_a[t]) || b_t[rd_c[t]] !== 12'(exp_b[t])) begin
                n_err++;
                $display("FAIL hold_addr[%0d]: got a=%0d b=%0d want a=%0d b=%0d", t, a_t[rd_c[t]], b_t[rd_c[t]], exp_a[t], exp_b[t]);
            end
        end
        n_cmp++;
        if (we_m !== 32'h2A20) begin n_err++; $display("FAIL hold_cwe: got %h want %h", we_m, 32'h2A20); end
        for (int t = 0; t < 4; t++) begin
            n_cmp++;
            if (ca_t[we_c[t]] !== 12'(t)) begin
                n_err++; $display("FAIL hold_caddr[%0d]: got %0d want %0d", t, ca_t[we_c[t]], t);
            end
        end
        n_cmp++;
        if (done_m !== 32'h4000) begin n_err++; $display("FAIL hold_done: got %h want %h", done_m, 32'h4000); end
    endtask

    task automatic test_restart_ignored();
        // Second start at cycle 3 and size inputs changed mid-run: both ignored.
        capture(20, 4'd1, 4'd1, 4'd1, 32'h0, 3, -1, 1'b1);
        n_cmp++;
        if (rd_m !== 32'h1FE) begin n_err++; $display("FAIL restart_rd: got %h want %h", rd_m, 32'h1FE); end
        n_cmp++;
        if (we_m !== 32'hAA0) begin n_err++; $display("FAIL restart_cwe: got %h want %h", we_m, 32'hAA0); end
        n_cmp++;
        if (done_m !== 32'h1000) begin n_err++; $display("FAIL restart_done: got %h want %h", done_m, 32'h1000); end
    endtask

    task automatic test_reset_abort();
        capture(20, 4'd1, 4'd1, 4'd1, 32'h0, -1, 6, 1'b0);
        n_cmp++;
        if (busy_m !== 32'h3E) begin n_err++; $display("FAIL abort_busy: got %h want %h", busy_m, 32'h3E); end
        n_cmp++;
        if (rd_m !== 32'h3E) begin n_err++; $display("FAIL abort_rd: got %h want %h", rd_m, 32'h3E); end
        n_cmp++;
        if (mac_m !== 32'h3C) begin n_err++; $display("FAIL abort_mac: got %h want %h", mac_m, 32'h3C); end
        n_cmp++;
        if (we_m !== 32'h20) begin n_err++; $display("FAIL abort_cwe: got %h want %h", we_m, 32'h20); end
        n_cmp++;
        if (done_m !== 32'h0) begin n_err++; $display("FAIL abort_done: got %h want %h", done_m, 32'h0); end
        // Fresh run after the abort starts again from address 0.
        capture(16, 4'd1, 4'd1, 4'd1, 32'h0, -1, -1, 1'b0);
        n_cmp++;
        if (a_t[1] !== 12'd0 || b_t[1] !== 12'd0 || a_t[5] !== 12'd2 || b_t[8] !== 12'd3) begin
            n_err++;
            $display("FAIL rerun_addr: got a1=%0d b1=%0d a5=%0d b8=%0d want 0 0 2 3", a_t[1], b_t[1], a_t[5], b_t[8]);
        end
        n_cmp++;
        if (we_m !== 32'hAA0 || ca_t[5] !== 12'd0 || ca_t[11] !== 12'd3) begin
            n_err++;
            $display("FAIL rerun_cwe: got %h c5=%0d c11=%0d want %h 0 3", we_m, ca_t[5], ca_t[11], 32'hAA0);
        end
        n_cmp++;
        if (done_m !== 32'h1000) begin n_err++; $display("FAIL rerun_done: got %h want %h", done_m, 32'h1000); end
    endtask

    task automatic test_k1();
        int exp_a [6] = '{0, 0, 0, 1, 1, 1};
        int exp_b [6] = '{0, 1, 2, 0, 1, 2};
        capture(14, 4'd1, 4'd0, 4'd2, 32'h0, -1, -1, 1'b0);
        n_cmp++;
        if (rd_m !== 32'h7E) begin n_err++; $display("FAIL k1_rd: got %h want %h", rd_m, 32'h7E); end
        for (int t = 0; t < 6; t++) begin
            n_cmp++;
            if (a_t[t+1] !== 12'(exp_a[t]) || b_t[t+1] !== 12'(exp_b[t])) begin
                n_err++;
                $display("FAIL k1_addr[%0d]: got a=%0d b=%0d want a=%0d b=%0d", t, a_t[t+1], b_t[t+1], exp_a[t], exp_b[t]);
            end
        end
        n_cmp++;
        if (clr_m !== 32'hFC) begin n_err++; $display("FAIL k1_clr: got %h want %h", clr_m, 32'hFC); end
        n_cmp++;
        if (we_m !== 32'h3F0) begin n_err++; $display("FAIL k1_cwe: got %h want %h", we_m, 32'h3F0); end
        for (int t = 0; t < 6; t++) begin
            n_cmp++;
            if (ca_t[t+4] !== 12'(t)) begin
                n_err++; $display("FAIL k1_caddr[%0d]: got %0d want %0d", t, ca_t[t+4], t);
            end
        end
        n_cmp++;
        if (done_m !== 32'h400) begin n_err++; $display("FAIL k1_done: got %h want %h", done_m, 32'h400); end
    endtask

    initial begin
        test_reset();
        test_1x1x1();
        test_2x2x2();
        test_hold();
        test_restart_ignored();
        test_reset_abort();
        test_k1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/macc_seq.md
Name: macc_seq

Overview:
- Sequencer for the matrix multiply-accumulate datapath. Computes C = A x B, with B stored transposed (row j of the B store is column j of B).
- Walks (i, j, k) loops and issues operand RAM addresses for A and B, plus the read strobe.
- Generates the delayed MAC enable, accumulator clear and result write strobe into the C store.
- Sits between the host command interface and the A/B/C matrix stores; owns those stores' read/write ports while busy.

Parameters:
- ADDR_MSB, 11, MSB of every RAM address.
- MAT_IDX_SIZE_MSB, 3, MSB of the size fields (size field = dimension - 1).
- RD_LAT, 1, cycles from rd_en to operand data valid at the multiplier (1..4).
- MAC_LAT, 2, cycles from a mac_en term to its accumulated result being valid (1..4).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE.
- hold  input  1  freeze operand issue (external RAM arbitration); in-flight terms keep draining.
- m_idx_size  input  MAT_IDX_SIZE_MSB+1  rows of A minus 1.
- k_idx_size  input  MAT_IDX_SIZE_MSB+1  inner dimension minus 1.
- n_idx_size  input  MAT_IDX_SIZE_MSB+1  columns of B minus 1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- rd_en  output  1  read strobe to the A and B stores.
- a_addr  output  ADDR_MSB+1  A address = i*(K) + k.
- b_addr  output  ADDR_MSB+1  B address = j*(K) + k.
- mac_en  output  1  multiply operands and add into the accumulator.
- acc_clr  output  1  with mac_en: load the product instead of accumulating.
- c_we  output  1  write the accumulator to the C store.
- c_addr  output  ADDR_MSB+1  C address = i*(N) + j.

Behaviour:
- Reset: state=IDLE; all counters 0; the pipe is empty. busy, done, rd_en, mac_en, acc_clr and c_we are 0; a_addr, b_addr and c_addr are 0.
- Reset mid-operation aborts immediately. No further c_we is issued.
- Sizes are latched when start is accepted. Input changes while busy are ignored.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after issuing the term (i=M-1, j=N-1, k=K-1).
  - DRAIN -> DONE when the pipe is empty.
  - DONE -> IDLE unconditionally.
- busy = state != IDLE. done = (state == DONE). start while busy is ignored.
- Issue (RUN, hold=0): rd_en=1, and the addresses reflect the current (i, j, k). k increments; on k wrap, j increments; on j wrap, i increments.
- Issue (RUN, hold=1): rd_en=0, and the counters and addresses hold.
- Address arithmetic uses running bases only, with no multipliers:
  - a_base += K on i increment.
  - b_base += K on j increment; b_base = 0 on j wrap.
  - a_addr = a_base + k; b_addr = b_base + k.
  - The c counter increments once per dot product.
  - All arithmetic is modulo 2^(ADDR_MSB+1).
- Each issued term enters a shift pipe carrying {valid, first (k==0), last (k==K-1), c_addr}.
  - mac_en = valid delayed RD_LAT; acc_clr = first delayed RD_LAT.
  - c_we = last delayed RD_LAT+MAC_LAT, with the matching c_addr presented in the same cycle.
- Latency: term issued in cycle t -> mac_en in t+RD_LAT; a last term in t -> c_we in t+RD_LAT+MAC_LAT.
- hold never stalls the pipe. A bubble only delays later terms and never corrupts the accumulation order.
- K=1: every term is both first and last, so acc_clr and c_we occur for every term.
- 1x1x1 is legal.
- The final c_we occurs in DRAIN; done is asserted in the cycle after it.

Test Plan:
- Reset, then start in cycle 0 with m=k=n idx_size=0 (defaults RD_LAT=1, MAC_LAT=2):
  - rd_en cycle 1 with a_addr=0, b_addr=0.
  - mac_en and acc_clr in cycle 2.
  - c_we with c_addr=0 in cycle 4.
  - done in cycle 5; busy high in cycles 1-5.
- 2x2x2 (all idx_size=1), start in cycle 0:
  - rd_en in cycles 1-8.
  - a_addr sequence 0,1,0,1,2,3,2,3; b_addr sequence 0,1,2,3,0,1,2,3.
  - acc_clr in cycles 2,4,6,8.
  - c_we in cycles 5,7,9,11 with c_addr 0,1,2,3.
  - done in cycle 12.
- Same as the 2x2x2 case, with hold=1 in cycles 3-4:
  - rd_en is low in cycles 3-4 and a_addr holds at 0.
  - All later events shift by +2; c_we in cycles 5,9,11,13; done in cycle 14.
- start pulsed again in cycle 3 of a run -> ignored: no extra rd_en, and exactly one done.
- RST asserted in cycle 6 of the 2x2x2 case -> busy, rd_en, mac_en and c_we drop immediately, and no c_we occurs afterward. A new start then runs the full sequence from address 0.
- k_idx_size=0, m=1, n=2 (idx_size): 6 terms, each with acc_clr and c_we, c_addr 0..5; b_addr 0,1,2,0,1,2; a_addr 0,0,0,1,1,1.
